// File: rtl/fifo_wr_arb_if.sv
// Bundle between NUM_SRC producers, the write arbiter and the sync FIFO write port.
// The master side is the arbiter. The slave side is the producers/FIFO environment.
interface fifo_wr_arb_if #(
    parameter int WIDTH   = 16,
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 2
);
    logic [NUM_SRC-1:0]       src_req;
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic [NUM_SRC-1:0]       src_last;
    logic [NUM_SRC-1:0]       src_gnt;
    logic                     fifo_full;
    logic                     fifo_wr_en;
    logic [WIDTH-1:0]         fifo_data_in;
    logic [SRC_W-1:0]         owner;
    logic                     busy;

    modport master (
        input  src_req, src_data, src_last, fifo_full,
        output src_gnt, fifo_wr_en, fifo_data_in, owner, busy
    );

    modport slave (
        output src_req, src_data, src_last, fifo_full,
        input  src_gnt, fifo_wr_en, fifo_data_in, owner, busy
    );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter sharing one sync FIFO write port among NUM_SRC producers.
// The write is combinational from the grant, so a beat lands in the cycle it is granted.
module fifo_wr_arb #(
    parameter int WIDTH     = 16,
    parameter int NUM_SRC   = 4,
    parameter int SRC_W     = 2,
    parameter int MAX_BURST = 4,
    parameter int BURST_W   = 3
) (
    input  logic          clk,
    input  logic          rst,
    fifo_wr_arb_if.master bus
);
    typedef enum logic {IDLE, BURST} state_t;

    state_t             state_reg, state_next;
    logic [SRC_W-1:0]   owner_reg, owner_next;
    logic [SRC_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [BURST_W-1:0] beat_cnt_reg, beat_cnt_next;

    logic [WIDTH-1:0]   src_slice [NUM_SRC];
    logic               xfer;
    logic               found;
    logic [SRC_W-1:0]   sel;
    int                 idx;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign src_slice[gi]   = bus.src_data[gi*WIDTH +: WIDTH];
        assign bus.src_gnt[gi] = xfer && (owner_reg == SRC_W'(gi));
    end

    // Gating with rst keeps a beat presented in the reset cycle from being written.
    assign xfer = (state_reg == BURST) && !rst &&
                  bus.src_req[owner_reg] && !bus.fifo_full;

    assign bus.fifo_wr_en   = xfer;
    assign bus.fifo_data_in = xfer ? src_slice[owner_reg] : '0;
    assign bus.owner        = owner_reg;
    assign bus.busy         = (state_reg == BURST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            owner_reg    <= '0;
            rr_ptr_reg   <= SRC_W'(NUM_SRC - 1);
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            rr_ptr_reg   <= rr_ptr_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        rr_ptr_next   = rr_ptr_reg;
        beat_cnt_next = beat_cnt_reg;
        found         = 1'b0;
        sel           = '0;
        idx           = 0;

        // Search upward from the source after the last one served, wrapping.
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(rr_ptr_reg) + k) % NUM_SRC;
            if (!found && bus.src_req[idx]) begin
                found = 1'b1;
                sel   = SRC_W'(idx);
            end
        end

        case (state_reg)
            IDLE: begin
                if (found) begin
                    state_next    = BURST;
                    owner_next    = sel;
                    rr_ptr_next   = sel;
                    beat_cnt_next = '0;
                end
            end
            BURST: begin
                if (!bus.src_req[owner_reg]) begin
                    state_next = IDLE;
                end else if (xfer) begin
                    beat_cnt_next = beat_cnt_reg + BURST_W'(1);
                    if (bus.src_last[owner_reg] ||
                        (beat_cnt_reg + BURST_W'(1)) == BURST_W'(MAX_BURST)) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: per-cycle reference model plus literal write/pattern checks.
module tb_fifo_wr_arb;
    localparam int WIDTH     = 16;
    localparam int NUM_SRC   = 4;
    localparam int SRC_W     = 2;
    localparam int MAX_BURST = 4;
    localparam int BURST_W   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_wr_arb_if #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SRC_W(SRC_W)) bus ();

    fifo_wr_arb #(
        .WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SRC_W(SRC_W),
        .MAX_BURST(MAX_BURST), .BURST_W(BURST_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Producer beat stores: {last, data}
    logic [16:0]        beat_mem [NUM_SRC][16];
    int                 head [NUM_SRC];
    int                 tail [NUM_SRC];
    logic [NUM_SRC-1:0] en;
    logic               full_force;

    logic [WIDTH-1:0] fq[$];
    bit               pat_q[$];
    int               own_q[$];
    bit               log_on = 1'b0;

    // Reference model: m_own = -1 means nobody holds the port
    int                 m_own       = -1;
    int                 m_beats     = 0;
    int                 m_last      = NUM_SRC - 1;
    int                 m_owner_out = 0;
    logic [NUM_SRC-1:0] exp_gnt     = '0;

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic check_str(string name, string got, string want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got '%s' want '%s'", name, got, want);
        end
    endtask

    always @(negedge clk) begin : compare
        logic [NUM_SRC-1:0] g;
        logic               w;
        logic [WIDTH-1:0]   d;
        bit                 hit;
        int                 c;
        g = '0;
        w = 1'b0;
        d = '0;
        if (!rst && m_own >= 0 && bus.src_req[m_own] && !bus.fifo_full) begin
            g[m_own] = 1'b1;
            w        = 1'b1;
            d        = bus.src_data[m_own*WIDTH +: WIDTH];
        end
        exp_gnt = g;
        check("src_gnt",      32'(bus.src_gnt),      32'(g));
        check("fifo_wr_en",   32'(bus.fifo_wr_en),   32'(w));
        check("fifo_data_in", 32'(bus.fifo_data_in), 32'(d));
        check("busy",         32'(bus.busy),         32'(m_own >= 0));
        check("owner",        32'(bus.owner),        32'(m_owner_out));
        check("wr_while_full", 32'(bus.fifo_wr_en & bus.fifo_full), 32'd0);

        if (bus.fifo_wr_en === 1'b1) begin
            fq.push_back(bus.fifo_data_in);
            if (log_on) own_q.push_back(int'(bus.owner));
        end
        if (log_on) pat_q.push_back(bus.fifo_wr_en === 1'b1);

        if (rst) begin
            m_own = -1; m_beats = 0; m_last = NUM_SRC - 1; m_owner_out = 0;
        end else if (m_own < 0) begin
            hit = 1'b0;
            for (int k = 1; k <= NUM_SRC; k++) begin
                c = (m_last + k) % NUM_SRC;
                if (!hit && bus.src_req[c]) begin
                    hit = 1'b1; m_own = c; m_owner_out = c; m_last = c; m_beats = 0;
                end
            end
        end else if (w) begin
            m_beats++;
            if (bus.src_last[m_own] || m_beats == MAX_BURST) m_own = -1;
        end else if (!bus.src_req[m_own]) begin
            m_own = -1;
        end
    end

    task automatic apply();
        for (int i = 0; i < NUM_SRC; i++) begin
            if (en[i] && head[i] < tail[i]) begin
                bus.src_req[i]                  = 1'b1;
                bus.src_data[i*WIDTH +: WIDTH]  = beat_mem[i][head[i]][WIDTH-1:0];
                bus.src_last[i]                 = beat_mem[i][head[i]][16];
            end else begin
                bus.src_req[i]                  = 1'b0;
                bus.src_data[i*WIDTH +: WIDTH]  = '0;
                bus.src_last[i]                 = 1'b0;
            end
        end
        bus.fifo_full = full_force || (fq.size() >= 16);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_SRC; i++) if (exp_gnt[i]) head[i]++;
    endtask

    task automatic push(int s, logic [15:0] d, bit l);
        beat_mem[s][tail[s]] = {l, d};
        tail[s]++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) begin head[i] = 0; tail[i] = 0; end
        en = '1;
        full_force = 1'b0;
        apply();
        tick();
        tick();
        rst = 1'b0;
        fq.delete(); pat_q.delete(); own_q.delete();
        apply();
    endtask

    task automatic set_ctl(int t, int c);
        case (t)
            5: full_force = (c >= 3 && c <= 5);
            6: en[0] = (c < 3);
            7: begin en[0] = (c >= 2); rst = (c == 2); end
            default: ;
        endcase
    endtask

    task automatic run(int t, int n);
        log_on = 1'b1;
        for (int c = 0; c < n; c++) begin
            set_ctl(t, c);
            apply();
            tick();
        end
        log_on = 1'b0;
        rst = 1'b0;
    endtask

    function automatic string pat_str(int n);
        string s = "";
        for (int i = 0; i < n && i < pat_q.size(); i++) s = {s, pat_q[i] ? "1" : "0"};
        return s;
    endfunction

    function automatic string data_str(int n);
        string s = "";
        for (int i = 0; i < n && i < fq.size(); i++) s = {s, $sformatf("%04h ", fq[i])};
        return s;
    endfunction

    function automatic string own_str(int n);
        string s = "";
        for (int i = 0; i < n && i < own_q.size(); i++) s = {s, $sformatf("%0d", own_q[i])};
        return s;
    endfunction

    initial begin
        bus.src_req = '0; bus.src_data = '0; bus.src_last = '0; bus.fifo_full = 1'b0;
        en = '1; full_force = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin head[i] = 0; tail[i] = 0; end

        // Reset then idle
        do_reset();
        run(1, 10);
        check_str("idle_pattern", pat_str(10), "0000000000");
        check("idle_owner", 32'(bus.owner), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        $display("reset/idle: writes='%s'", data_str(16));

        // Single source, bursts split at MAX_BURST
        do_reset();
        for (int k = 0; k < 6; k++) push(2, 16'h00A0 + 16'(k), 1'b0);
        run(2, 12);
        check_str("single_pattern", pat_str(9), "011110110");
        check_str("single_data", data_str(16), "00a0 00a1 00a2 00a3 00a4 00a5 ");
        $display("single source: writes='%s'", data_str(16));

        // Round robin with src_last on every beat
        do_reset();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < NUM_SRC; i++) push(i, 16'h1000 * 16'(i + 1) + 16'(k), 1'b1);
        run(3, 30);
        check_str("rr_pattern", pat_str(6), "010101");
        check_str("rr_owners", own_str(6), "012301");
        check_str("rr_data", data_str(16),
                  "1000 2000 3000 4000 1001 2001 3001 4001 1002 2002 3002 4002 ");
        $display("round robin: owners='%s'", own_str(12));

        // Early last on source 1's 2nd beat
        do_reset();
        push(1, 16'h00B0, 1'b0); push(1, 16'h00B1, 1'b1);
        push(1, 16'h00B2, 1'b0); push(1, 16'h00B3, 1'b0);
        for (int k = 0; k < 4; k++) push(2, 16'h00C0 + 16'(k), 1'b0);
        run(4, 16);
        check_str("early_pattern", pat_str(12), "011011110110");
        check_str("early_data", data_str(16), "00b0 00b1 00c0 00c1 00c2 00c3 00b2 00b3 ");
        $display("early last: writes='%s'", data_str(16));

        // Full stall mid-burst on source 3
        do_reset();
        for (int k = 0; k < 4; k++) push(3, 16'h00D0 + 16'(k), 1'b0);
        run(5, 12);
        check_str("stall_pattern", pat_str(9), "011000110");
        check_str("stall_owners", own_str(8), "3333");
        check_str("stall_data", data_str(16), "00d0 00d1 00d2 00d3 ");
        $display("full stall: writes='%s'", data_str(16));

        // Source 0 releases mid-burst, source 1 follows
        do_reset();
        for (int k = 0; k < 4; k++) push(0, 16'h00E0 + 16'(k), 1'b0);
        push(1, 16'h00F0, 1'b0); push(1, 16'h00F1, 1'b1);
        run(6, 10);
        check_str("release_pattern", pat_str(8), "01100110");
        check_str("release_owners", own_str(8), "0011");
        check_str("release_data", data_str(16), "00e0 00e1 00f0 00f1 ");
        $display("release: writes='%s'", data_str(16));

        // Reset during a beat of source 2; source 0 wins afterwards
        do_reset();
        for (int k = 0; k < 4; k++) push(2, 16'h0110 + 16'(k), 1'b0);
        push(0, 16'h0120, 1'b1);
        run(7, 12);
        check_str("rst_pattern", pat_str(10), "0100101110");
        check_str("rst_owners", own_str(8), "20222");
        check_str("rst_data", data_str(16), "0110 0120 0111 0112 0113 ");
        $display("reset mid-burst: writes='%s'", data_str(16));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
